// File: rtl/mp_add_seq_pkg.sv
// mp_add_seq_pkg: shared FSM encoding and index-width helper for the multi-precision sequencer
package mp_add_seq_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) ;
    return r;
  endfunction
endpackage

// File: rtl/mp_add_seq_rca_word.sv
// rca_word: N-bit ripple-carry adder built from a chain of full adders
module rca_word #(
  parameter int N = 8
) (
  output logic         carry_out,
  output logic [N-1:0] sum_out,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         carry_in
);
  logic [N:0] c;
  assign c[0] = carry_in;
  assign carry_out = c[N];
  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum_out[i] = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
endmodule

// File: rtl/mp_add_seq.sv
// mp_add_seq: word-serial WORDS*N-bit add/subtract through one shared N-bit ripple adder
module mp_add_seq
  import mp_add_seq_pkg::*;
#(
  parameter int N     = 8,
  parameter int WORDS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [N*WORDS-1:0] a,
  input  logic [N*WORDS-1:0] b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [N*WORDS-1:0] sum_out,
  output logic             carry_out,
  output logic             overflow
);
  localparam int IW = clog2(WORDS);
  state_t state, state_nx;
  logic [IW-1:0] idx;
  logic [N*WORDS-1:0] la, lb;
  logic sub_l, cr, co, last, acc;
  logic [N-1:0] aw, bw, s;
  assign aw = la[int'(idx)*N +: N];
  assign bw = lb[int'(idx)*N +: N] ^ {N{sub_l}};
  assign busy = state == RUN;
  assign done = state == DONE;
  rca_word #(.N(N)) u_rca (
    .carry_out(co),
    .sum_out  (s),
    .a        (aw),
    .b        (bw),
    .carry_in (cr)
  );
  // next state: RUN ends on the last word; IDLE and DONE both accept a new start
  always_comb begin
    last = idx == IW'(WORDS - 1);
    acc = !busy && start;
    state_nx = busy ? (last ? DONE : RUN) : (start ? RUN : IDLE);
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // operand latch on accept, then one result word and carry per RUN cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx <= '0;
      la <= '0;
      lb <= '0;
      sub_l <= 1'b0;
      cr <= 1'b0;
      sum_out <= '0;
      carry_out <= 1'b0;
      overflow <= 1'b0;
    end else if (acc) begin
      la <= a;
      lb <= b;
      sub_l <= sub;
      cr <= sub | carry_in;
      idx <= '0;
    end else if (busy) begin
      sum_out[int'(idx)*N +: N] <= s;
      cr <= co;
      if (last) begin
        carry_out <= co;
        overflow <= (aw[N-1] == bw[N-1]) && (s[N-1] != aw[N-1]);
      end else idx <= idx + 1'b1;
    end
endmodule

// File: tb/tb_mp_add_seq.sv
// tb_mp_add_seq: scoreboard bench for the word-serial add/subtract sequencer
module tb_mp_add_seq;
  localparam int N = 8, WORDS = 4, W = N * WORDS;
  logic clk = 0, rst_n = 0, start = 0, sub = 0, carry_in = 0;
  logic [W-1:0] a = '0, b = '0, sum_out;
  logic busy, done, carry_out, overflow;
  typedef struct {
    logic [W-1:0] s;
    logic c;
    logic o;
    int cyc;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0, failures = 0, cyc = 0, dones = 0, d0;

  mp_add_seq #(.N(N), .WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .carry_in(carry_in), .busy(busy), .done(done), .sum_out(sum_out),
    .carry_out(carry_out), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk)
    if (rst_n === 1'b1 && done === 1'b1) begin
      dones++;
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0 cyc=%0d", cyc);
      end else begin
        e = q.pop_front();
        chk("sum_out", sum_out, e.s);
        chk("carry_out", carry_out, e.c);
        chk("overflow", overflow, e.o);
        chk("done_cycle", cyc, e.cyc);
      end
    end

  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                       input logic cv, input logic track, input logic [W-1:0] es,
                       input logic ec, input logic eo);
    @(negedge clk);
    a = av;
    b = bv;
    sub = sv;
    carry_in = cv;
    start = 1;
    if (track) q.push_back('{es, ec, eo, cyc + WORDS + 1});
    @(negedge clk);
    start = 0;
    a = ~av;
    b = ~bv;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL timeout pending=%0d required=0", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum_out, 0);
    chk("rst_cout", carry_out, 0);
    chk("rst_ovf", overflow, 0);
    rst_n = 1;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    issue(32'h000000FF, 32'h00000001, 0, 0, 1, 32'h00000100, 0, 0);
    drain();
    issue(32'hFFFFFFFF, 32'h00000001, 0, 0, 1, 32'h00000000, 1, 0);
    drain();
    issue(32'h7FFFFFFF, 32'h00000001, 0, 0, 1, 32'h80000000, 0, 1);
    drain();
    issue(32'hFFFFFFFF, 32'h00000000, 0, 1, 1, 32'h00000000, 1, 0);
    drain();
    issue(32'h00000000, 32'h00000001, 1, 0, 1, 32'hFFFFFFFF, 0, 0);
    drain();
    issue(32'h00000020, 32'h00000020, 1, 1, 1, 32'h00000000, 1, 0);
    drain();

    issue(32'h11111111, 32'h22222222, 0, 0, 1, 32'h33333333, 0, 0);
    @(negedge clk);
    a = 32'h01010101;
    b = 32'h40404040;
    start = 1;
    @(negedge clk);
    start = 0;
    a = 32'hDEADBEEF;
    b = 32'hCAFEF00D;
    drain();

    issue(32'h00000001, 32'h00000002, 0, 0, 1, 32'h00000003, 0, 0);
    repeat (3) @(negedge clk);
    issue(32'h00000020, 32'h00000020, 0, 1, 1, 32'h00000041, 0, 0);
    drain();

    issue(32'h01020304, 32'h01010101, 0, 0, 0, '0, 0, 0);
    repeat (2) @(negedge clk);
    d0 = dones;
    rst_n = 0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_sum", sum_out, 0);
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (8) @(negedge clk);
    chk("midrst_no_done", dones, d0);
    chk("midrst_sum_held", sum_out, 0);
    issue(32'h12345678, 32'h11111111, 0, 0, 1, 32'h23456789, 0, 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mp_add_seq.md
# mp_add_seq

Multi-precision add/subtract sequencer. It computes a WORDS×N-bit sum or difference by feeding one N-bit word per cycle, least-significant word first, through a single N-bit ripple-carry adder. The carry between words is held in a register. The block sits in front of the generate-built ripple-carry datapath, so wide arithmetic reuses one narrow adder instead of instantiating a WORDS×N-bit ripple chain.

## Interface
Parameters:
- N, 8, word width in bits; width of the shared ripple-carry adder.
- WORDS, 4, number of words per operand; must be ≥ 2.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a new operation; sampled only when the block is not busy.
- sub  input  1  0 = a+b+carry_in; 1 = a−b (carry_in ignored).
- a  input  N*WORDS  operand A; latched on the accepting edge.
- b  input  N*WORDS  operand B; latched on the accepting edge.
- carry_in  input  1  initial carry for add mode.
- busy  output  1  high while words are being processed.
- done  output  1  one-cycle pulse when the result is complete.
- sum_out  output  N*WORDS  result; valid from done until the next accepted start.
- carry_out  output  1  final carry (add mode); inverted borrow (sub mode, 1 = no borrow).
- overflow  output  1  signed overflow of the full-width result.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE: if start=1 at an edge, latch a, b and sub, then go to RUN with idx=0.
    - Carry register loads carry_in when sub=0, and 1 when sub=1.
  - RUN: each edge captures adder word idx into sum_out[idx*N +: N] and the adder carry into the carry register, then increments idx.
    - When idx reaches WORDS−1, the same edge moves the FSM to DONE.
  - DONE: done=1 for exactly this cycle.
    - start=1 here is accepted exactly as in IDLE (back-to-back operation) and moves the FSM to RUN.
    - Otherwise the FSM returns to IDLE.
- Adder inputs during RUN:
  - A side: latched_a word idx.
  - B side: latched_b word idx, bitwise inverted when sub=1.
  - Carry in: the carry register.
- carry_out is the adder carry from word WORDS−1.
- overflow: (msbA == msbB') && (msb_sum != msbA), where B' is the inverted-or-not operand B; evaluated on the last word.
- start while busy=1 is ignored; the latched operands do not change.
- a and b may change freely after the accepting edge.
- sum_out words are updated progressively during RUN. They are guaranteed valid only from done onward, and hold until the next RUN begins.

## Timing
- Reset values: FSM=IDLE, idx=0, busy=0, done=0, sum_out=0, carry_out=0, overflow=0, carry register=0, latched operands=0.
- Latency: start accepted at edge k.
  - busy is high from edge k to edge k+WORDS.
  - done is high from edge k+WORDS to edge k+WORDS+1.
- Throughput: one operation per WORDS+1 cycles. With back-to-back start in DONE, one operation per WORDS+1 cycles with no IDLE gap.
- idx width is clog2(WORDS). idx stops at WORDS−1 and never wraps past it.
- The carry path from the carry register through the adder to the carry register is the only combinational loop-free critical path. It is N full-adder stages long.
- rst_n asserted mid-RUN:
  - All state clears immediately.
  - done does not pulse.
  - The partial result is discarded (sum_out=0).
- rst_n deasserted with start=1: start is sampled from the first rising edge after release.

## Structure
- Shared package/header holds:
  - FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - a clog2 helper for idx width.
- One sub-module: rca_word.
  - Parameterised N-bit ripple-carry adder, built with a generate loop of full adders.
  - Ports (carry_out, sum_out, a, b, carry_in).
  - Instantiated once; it is the shared datapath.
- Everything else (FSM, idx counter, carry register, operand latches, result register) lives in mp_add_seq.

## Test plan
All scenarios use N=8, WORDS=4.
- Add, inter-word carry: a=0x000000FF, b=0x00000001, cin=0 -> sum_out=0x00000100, carry_out=0, overflow=0. done exactly 4 cycles after the start edge.
- Full wrap: a=0xFFFFFFFF, b=0x00000001, cin=0 -> sum_out=0x00000000, carry_out=1, overflow=0. Then a=0x7FFFFFFF, b=1 -> 0x80000000, overflow=1.
- Subtract with borrow: sub=1, a=0x00000000, b=0x00000001 -> sum_out=0xFFFFFFFF, carry_out=0. Then sub=1, a=0x00000020, b=0x00000020 -> 0x00000000, carry_out=1.
- Start while busy: start with a=0x11111111, b=0x22222222. Pulse start with different operands 2 cycles later, then change a/b. Required: one done only, sum_out=0x33333333.
- Back-to-back: assert start in the DONE cycle with new operands (0x00000020+0x00000020, cin=1). Required: RUN follows immediately, second done 5 cycles after the first, sum_out=0x00000041.
- Reset mid-run: rst_n low during idx=2. Required: busy=0, done never pulses, sum_out=0 immediately. A new start after release completes normally.
